// File: rtl/slot_burst_tx_pkg.sv
// Shared widths, the stored slot layout and the transmitter state type
// for the slot-buffering write path.
package slot_burst_tx_pkg;

    localparam int PDATA_WIDTH    = 32;
    localparam int PCOMPLETE_DATA = 16;
    localparam int PID_WIDTH      = 4;
    localparam int PLENGTH_WIDTH  = 8;
    localparam int PADDR_WIDTH    = 32;
    localparam int PUSER_WIDTH    = 4;

    localparam int PBEAT_BYTES = PDATA_WIDTH / 8;
    localparam int MAX_BEATS   = PCOMPLETE_DATA / PBEAT_BYTES;
    localparam int BEAT_IDX_W  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

    // One complete write transaction: address phase plus the whole payload,
    // byte 0 in the least significant bits of data/strb.
    typedef struct packed {
        logic [PID_WIDTH-1:0]        awid;
        logic [PADDR_WIDTH-1:0]      awaddr;
        logic [PLENGTH_WIDTH-1:0]    awlen;
        logic [2:0]                  awsize;
        logic [1:0]                  awburst;
        logic [PUSER_WIDTH-1:0]      awuser;
        logic [PCOMPLETE_DATA*8-1:0] data;
        logic [PCOMPLETE_DATA-1:0]   strb;
    } spec_slot;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } tx_state_t;

    // Index of the final beat actually sent: bursts longer than the slot
    // payload are cut at the last stored beat.
    function automatic logic [PLENGTH_WIDTH:0] eff_len_of(input logic [PLENGTH_WIDTH-1:0] awlen);
        if (awlen > PLENGTH_WIDTH'(MAX_BEATS - 1)) begin
            return (PLENGTH_WIDTH + 1)'(MAX_BEATS - 1);
        end
        return {1'b0, awlen};
    endfunction

endpackage

// File: rtl/slot_burst_tx_if.sv
// AXI write address and write data channels, split into separate modports
// so a block can own one channel without the other.
interface axi_if;
    import slot_burst_tx_pkg::*;

    logic                     awvalid;
    logic                     awready;
    logic [PID_WIDTH-1:0]     awid;
    logic [PADDR_WIDTH-1:0]   awaddr;
    logic [PLENGTH_WIDTH-1:0] awlen;
    logic [2:0]               awsize;
    logic [1:0]               awburst;
    logic [PUSER_WIDTH-1:0]   awuser;

    logic                     wvalid;
    logic                     wready;
    logic [PDATA_WIDTH-1:0]   wdata;
    logic [PBEAT_BYTES-1:0]   wstrb;
    logic                     wlast;

    modport master_add (
        output awvalid, awid, awaddr, awlen, awsize, awburst, awuser,
        input  awready
    );

    modport master_data (
        output wvalid, wdata, wstrb, wlast,
        input  wready
    );

    modport slave_add (
        input  awvalid, awid, awaddr, awlen, awsize, awburst, awuser,
        output awready
    );

    modport slave_data (
        input  wvalid, wdata, wstrb, wlast,
        output wready
    );

endinterface

// File: rtl/slot_burst_tx.sv
// Replays one stored slot as an AXI write burst: address phase first, then
// the stored data beats, re-arming tran_ready after the last beat is taken.
module slot_burst_tx
    import slot_burst_tx_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      tran_valid,
    input  spec_slot  in_slot,
    output logic      tran_ready,
    output logic      len_err,
    axi_if.master_add  m_add,
    axi_if.master_data m_data
);

    tx_state_t              state_q;
    tx_state_t              state_d;
    spec_slot               slot_q;
    logic [PLENGTH_WIDTH:0] beat_q;
    logic [PLENGTH_WIDTH:0] eff_len;
    logic [BEAT_IDX_W-1:0]  beat_idx;
    logic                   accept;
    logic                   awvalid;
    logic                   wvalid;
    logic                   wlast;

    assign eff_len  = eff_len_of(slot_q.awlen);
    // beat_q never exceeds eff_len while a beat is presented, so the low bits suffice
    assign beat_idx = beat_q[BEAT_IDX_W-1:0];
    assign accept   = tran_valid & tran_ready;

    // Next-state and handshake outputs from the current phase
    always_comb begin
        state_d    = state_q;
        tran_ready = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        wlast      = 1'b0;
        case (state_q)
            IDLE: begin
                tran_ready = 1'b1;
                if (tran_valid) state_d = ADDR;
            end
            ADDR: begin
                awvalid = 1'b1;
                if (m_add.awready) state_d = DATA;
            end
            DATA: begin
                wvalid = 1'b1;
                wlast  = (beat_q == eff_len);
                if (m_data.wready && wlast) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Phase register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Slot capture, beat counter and over-length flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q  <= '0;
            beat_q  <= '0;
            len_err <= 1'b0;
        end else begin
            len_err <= accept && (in_slot.awlen > PLENGTH_WIDTH'(MAX_BEATS - 1));
            if (accept) begin
                slot_q <= in_slot;
                beat_q <= '0;
            end else if (wvalid && m_data.wready) begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    assign m_add.awvalid = awvalid;
    assign m_add.awid    = slot_q.awid;
    assign m_add.awaddr  = slot_q.awaddr;
    assign m_add.awlen   = slot_q.awlen;
    assign m_add.awsize  = slot_q.awsize;
    assign m_add.awburst = slot_q.awburst;
    assign m_add.awuser  = slot_q.awuser;

    assign m_data.wvalid = wvalid;
    assign m_data.wlast  = wlast;
    assign m_data.wdata  = slot_q.data[beat_idx*PDATA_WIDTH +: PDATA_WIDTH];
    assign m_data.wstrb  = slot_q.strb[beat_idx*PBEAT_BYTES +: PBEAT_BYTES];

endmodule

// File: tb/tb_slot_burst_tx.sv
// Bench for slot_burst_tx: table of directed bursts, randomized bursts with
// random backpressure, reset-idle and reset-mid-burst sequences.
module tb_slot_burst_tx;
    import slot_burst_tx_pkg::*;

    logic     clk = 1'b0;
    logic     rst_n = 1'b0;
    logic     tran_valid = 1'b0;
    spec_slot in_slot = '0;
    logic     tran_ready;
    logic     len_err;

    axi_if bus();

    slot_burst_tx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tran_valid (tran_valid),
        .in_slot    (in_slot),
        .tran_ready (tran_ready),
        .len_err    (len_err),
        .m_add      (bus),
        .m_data     (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [PID_WIDTH-1:0]     id;
        logic [PADDR_WIDTH-1:0]   addr;
        logic [PLENGTH_WIDTH-1:0] len;
        int                       aw_delay;
        int                       wmode;
        int                       exp_beats;
        logic                     exp_err;
        logic [PDATA_WIDTH-1:0]   exp_w0;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the slot is a byte array; beat k carries bytes k*PBEAT_BYTES..
    function automatic int model_nbeats(input spec_slot s);
        if (int'(s.awlen) > MAX_BEATS - 1) return MAX_BEATS;
        return int'(s.awlen) + 1;
    endfunction

    function automatic logic [PDATA_WIDTH-1:0] model_word(input spec_slot s, input int k);
        logic [PDATA_WIDTH-1:0] w;
        w = '0;
        for (int b = 0; b < PBEAT_BYTES; b++) w[8*b +: 8] = s.data[8*(k*PBEAT_BYTES + b) +: 8];
        return w;
    endfunction

    function automatic logic [PBEAT_BYTES-1:0] model_strb(input spec_slot s, input int k);
        logic [PBEAT_BYTES-1:0] m;
        m = '0;
        for (int b = 0; b < PBEAT_BYTES; b++) m[b] = s.strb[k*PBEAT_BYTES + b];
        return m;
    endfunction

    function automatic spec_slot noise_slot();
        logic [$bits(spec_slot)-1:0] v;
        for (int i = 0; i < $bits(spec_slot); i++) v[i] = 1'($urandom_range(0, 1));
        return spec_slot'(v);
    endfunction

    // Offer one slot at the current sample point and follow it to completion.
    // wmode: 0 wready always high, 1 toggling 1/0, 2 random.
    task automatic run_slot(input spec_slot s, input int aw_delay, input int wmode,
                            input int exp_beats, input logic exp_err,
                            input bit use_w0, input logic [PDATA_WIDTH-1:0] exp_w0,
                            input bit noise);
        int nb, beats, aw_wait, err_cnt, iters;
        bit aw_done, done, stall_prev, tog;
        logic [PDATA_WIDTH+PBEAT_BYTES:0] prev_w;
        nb = model_nbeats(s);
        beats = 0; aw_wait = 0; err_cnt = 0; iters = 0;
        aw_done = 0; done = 0; stall_prev = 0; tog = 0; prev_w = '0;

        check("idle_ready", tran_ready, 1);
        tran_valid = 1'b1;
        in_slot = s;
        @(posedge clk); #1;
        tran_valid = 1'b0;
        in_slot = noise_slot();
        check("accept_ready_low", tran_ready, 0);
        check("accept_awvalid", bus.awvalid, 1);
        check("len_err_pulse", len_err, exp_err);

        for (int cyc = 0; cyc < 300 && !done; cyc++) begin
            iters++;
            err_cnt += int'(len_err);
            check("aw_w_exclusive", bus.awvalid & bus.wvalid, 0);
            if (bus.awvalid)
                check("aw_fields", {bus.awid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst, bus.awuser},
                      {s.awid, s.awaddr, s.awlen, s.awsize, s.awburst, s.awuser});
            if (bus.wvalid && !aw_done) check("w_before_aw", 1, 0);
            if (bus.wvalid && stall_prev)
                check("w_stable", {bus.wdata, bus.wstrb, bus.wlast}, prev_w);

            if (bus.awvalid) begin
                bus.awready = (aw_wait >= aw_delay);
                aw_wait++;
            end else begin
                bus.awready = 1'b0;
            end
            case (wmode)
                0:       bus.wready = 1'b1;
                1:       begin tog = ~tog; bus.wready = tog; end
                default: bus.wready = 1'($urandom_range(0, 1));
            endcase
            if (noise) begin
                tran_valid = 1'($urandom_range(0, 1));
                in_slot = noise_slot();
            end

            if (bus.awvalid && bus.awready) aw_done = 1;
            if (bus.wvalid && bus.wready) begin
                if (beats < MAX_BEATS) begin
                    check("wdata", bus.wdata, model_word(s, beats));
                    check("wstrb", bus.wstrb, model_strb(s, beats));
                end
                check("wlast", bus.wlast, (beats == nb - 1));
                if (beats == 0 && use_w0) check("w0_const", bus.wdata, exp_w0);
                beats++;
                if (bus.wlast || beats >= MAX_BEATS + 1) done = 1;
            end
            stall_prev = bus.wvalid && !bus.wready;
            prev_w = {bus.wdata, bus.wstrb, bus.wlast};
            @(posedge clk); #1;
        end
        tran_valid = 1'b0;
        bus.awready = 1'b0;
        bus.wready = 1'b0;

        check("burst_done", done, 1);
        check("beat_count", beats, exp_beats);
        check("len_err_count", err_cnt, int'(exp_err));
        check("post_len_err", len_err, 0);
        check("post_ready", tran_ready, 1);
        check("post_wvalid", bus.wvalid, 0);
        check("post_wlast", bus.wlast, 0);
        check("post_awvalid", bus.awvalid, 0);
        if (aw_delay == 0 && wmode == 0) check("occupancy", iters, nb + 1);
    endtask

    function automatic spec_slot vec_slot(input vec_t v, input int i);
        spec_slot s;
        s = '0;
        s.awid    = v.id;
        s.awaddr  = v.addr;
        s.awlen   = v.len;
        s.awsize  = 3'd2;
        s.awburst = 2'd1;
        s.awuser  = PUSER_WIDTH'(i);
        for (int j = 0; j < PCOMPLETE_DATA; j++) s.data[8*j +: 8] = 8'(16*i + j);
        s.strb = '1;
        return s;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        spec_slot s;
        int hs;

        //          id  addr          len    dly mode beats err  first word
        vecs[0] = '{4'd3,  32'h100, 8'd3,   0, 0, 4, 1'b0, 32'h03020100};
        vecs[1] = '{4'd5,  32'h200, 8'd3,   3, 1, 4, 1'b0, 32'h13121110};
        vecs[2] = '{4'd1,  32'h040, 8'd0,   0, 0, 1, 1'b0, 32'h23222120};
        vecs[3] = '{4'd7,  32'h300, 8'd7,   1, 0, 4, 1'b1, 32'h33323130};
        vecs[4] = '{4'd2,  32'h080, 8'd1,   2, 1, 2, 1'b0, 32'h43424140};
        vecs[5] = '{4'd15, 32'hFFC, 8'd255, 0, 1, 4, 1'b1, 32'h53525150};
        vecs[6] = '{4'd9,  32'h500, 8'd4,   0, 0, 4, 1'b1, 32'h63626160};
        vecs[7] = '{4'd4,  32'h600, 8'd2,   0, 1, 3, 1'b0, 32'h73727170};

        bus.awready = 1'b0;
        bus.wready  = 1'b0;

        // Values held during reset
        #12;
        check("rst_tran_ready", tran_ready, 1);
        check("rst_len_err", len_err, 0);
        check("rst_valids", {bus.awvalid, bus.wvalid, bus.wlast}, 0);
        check("rst_aw_fields", {bus.awid, bus.awaddr, bus.awlen, bus.awsize, bus.awburst, bus.awuser}, 0);
        check("rst_w_fields", {bus.wdata, bus.wstrb}, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Idle with no offers
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("idle_hold", {tran_ready, bus.awvalid, bus.wvalid}, 3'b100);
        end

        // Directed table, issued back to back
        for (int i = 0; i < 8; i++)
            run_slot(vec_slot(vecs[i], i), vecs[i].aw_delay, vecs[i].wmode,
                     vecs[i].exp_beats, vecs[i].exp_err, 1'b1, vecs[i].exp_w0, 1'b0);

        // Reset during beat 2
        s = vec_slot(vecs[0], 9);
        tran_valid = 1'b1;
        in_slot = s;
        @(posedge clk); #1;
        tran_valid = 1'b0;
        bus.awready = 1'b1;
        bus.wready = 1'b1;
        hs = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (bus.wvalid) begin
                if (hs == 2) break;
                hs++;
            end
            @(posedge clk); #1;
        end
        check("mid_reach_beat2", {bus.wvalid, bus.wdata}, {1'b1, model_word(s, 2)});
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valids", {bus.awvalid, bus.wvalid, bus.wlast}, 0);
        check("mid_rst_ready", tran_ready, 1);
        check("mid_rst_fields", {bus.wdata, bus.wstrb, bus.awaddr}, 0);
        bus.awready = 1'b0;
        bus.wready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_slot(vec_slot(vecs[7], 10), 0, 0, 3, 1'b0, 1'b0, '0, 1'b0);

        // Randomized slots with random backpressure and input noise
        for (int n = 0; n < 40; n++) begin
            s = noise_slot();
            s.awlen = PLENGTH_WIDTH'($urandom_range(0, 9));
            run_slot(s, int'($urandom_range(0, 3)), 2, model_nbeats(s),
                     (int'(s.awlen) > MAX_BEATS - 1), 1'b0, '0, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
